alu_add_accum: RTL and testbench



---
 rtl/alu_add_accum.sv | 188 ++++++++++++++++++
 tb/tb_alu_add_accum.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_add_accum.sv
// Pipelined multi-lane ADD/SUB/ABSDIFF reducer with per-packet accumulation.
// Stage 1 registers per-lane results; stage 2 reduces lanes, accumulates and emits the packet total.
module alu_add_accum #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 40,
  parameter int SAT       = 0
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic [LANES*WIDTH-1:0]     In_A,
  input  logic [LANES*WIDTH-1:0]     In_B,
  input  logic [1:0]                 In_Mode,
  input  logic                       In_Last,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [ACC_WIDTH-1:0]       Out_Sum,
  output logic                       Out_Ovf
);

  localparam int LW = WIDTH + 1;
  localparam int GW = ACC_WIDTH + 1;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ABS = 2'b10;

  localparam logic [ACC_WIDTH-1:0] SIGNED_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SIGNED_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] UNSIGNED_MAX = {ACC_WIDTH{1'b1}};

  typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  pkt_mode_q, pkt_mode_d;
  logic                        s1_valid_q, s1_valid_d;
  logic                        s1_first_q, s1_first_d;
  logic                        s1_last_q, s1_last_d;
  logic [1:0]                  s1_mode_q, s1_mode_d;
  logic [LANES-1:0][LW-1:0]    s1_lane_q, s1_lane_d;
  logic [ACC_WIDTH-1:0]        acc_q, acc_d;
  logic                        ovf_q, ovf_d;
  logic                        out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]        out_sum_q, out_sum_d;
  logic                        out_ovf_q, out_ovf_d;

  logic                        en;
  logic                        accept;
  logic [1:0]                  beat_mode;
  logic [LANES-1:0][LW-1:0]    lane_res;
  logic [GW-1:0]               beat_sum;
  logic [GW-1:0]               acc_base;
  logic [GW-1:0]               sum_g;
  logic                        step_ovf;
  logic [ACC_WIDTH-1:0]        acc_new;
  logic                        ovf_new;

  assign en       = !out_valid_q || Out_Ready;
  assign accept   = In_Valid && en;
  assign In_Ready = en;

  // Mode is only taken from the bus on a packet's first beat; 11 aliases ADD.
  assign beat_mode = (state_q == ST_IDLE) ? ((In_Mode == 2'b11) ? MODE_ADD : In_Mode)
                                          : pkt_mode_q;

  // Each lane result is one bit wider than the operands, so it is exact in every mode.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] a_lane, b_lane;
    logic [LW-1:0]    a_s, b_s, a_u, b_u;
    assign a_lane = In_A[gi*WIDTH +: WIDTH];
    assign b_lane = In_B[gi*WIDTH +: WIDTH];
    assign a_s = {a_lane[WIDTH-1], a_lane};
    assign b_s = {b_lane[WIDTH-1], b_lane};
    assign a_u = {1'b0, a_lane};
    assign b_u = {1'b0, b_lane};
    assign lane_res[gi] = (beat_mode == MODE_SUB) ? (a_s - b_s) :
                          (beat_mode == MODE_ABS) ? ((a_u >= b_u) ? (a_u - b_u) : (b_u - a_u)) :
                          (a_s + b_s);
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + {{(GW-LW){s1_lane_q[i][LW-1]}}, s1_lane_q[i]};
    end
  end

  // One guard bit: ABSDIFF treats the accumulator as unsigned, ADD/SUB as signed.
  always_comb begin
    acc_base = '0;
    if (!s1_first_q) begin
      acc_base = (s1_mode_q == MODE_ABS) ? {1'b0, acc_q} : {acc_q[ACC_WIDTH-1], acc_q};
    end
    sum_g    = acc_base + beat_sum;
    step_ovf = (s1_mode_q == MODE_ABS) ? sum_g[GW-1] : (sum_g[GW-1] ^ sum_g[GW-2]);
    acc_new  = sum_g[ACC_WIDTH-1:0];
    if (step_ovf && (SAT != 0)) begin
      if (s1_mode_q == MODE_ABS) begin
        acc_new = UNSIGNED_MAX;
      end else begin
        acc_new = sum_g[GW-1] ? SIGNED_MIN : SIGNED_MAX;
      end
    end
    ovf_new = (s1_first_q ? 1'b0 : ovf_q) | step_ovf;
  end

  always_comb begin
    state_d     = state_q;
    pkt_mode_d  = pkt_mode_q;
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_mode_d   = s1_mode_q;
    s1_lane_d   = s1_lane_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;

    if (en) begin
      s1_valid_d = accept;
      s1_first_d = (state_q == ST_IDLE);
      s1_last_d  = In_Last;
      s1_mode_d  = beat_mode;
      s1_lane_d  = lane_res;

      if (accept) begin
        state_d = In_Last ? ST_IDLE : ST_ACCUM;
        if (state_q == ST_IDLE) begin
          pkt_mode_d = beat_mode;
        end
      end

      // en implies any held result is being consumed on this edge.
      out_valid_d = s1_valid_q && s1_last_q;

      if (s1_valid_q) begin
        if (s1_last_q) begin
          acc_d     = '0;
          ovf_d     = 1'b0;
          out_sum_d = acc_new;
          out_ovf_d = ovf_new;
        end else begin
          acc_d = acc_new;
          ovf_d = ovf_new;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      pkt_mode_q  <= MODE_ADD;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= MODE_ADD;
      s1_lane_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_mode_q  <= pkt_mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      s1_lane_q   <= s1_lane_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign Out_Valid = out_valid_q;
  assign Out_Sum   = out_sum_q;
  assign Out_Ovf   = out_ovf_q;

endmodule

// File: tb/tb_alu_add_accum.sv
// Directed bench for alu_add_accum: default instance plus two narrow instances for overflow (SAT=1 / SAT=0).
module tb_alu_add_accum;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  // default-parameter instance
  logic         in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [127:0] in_a, in_b;
  logic [1:0]   in_mode;
  logic [39:0]  out_sum;

  // narrow instances share inputs
  logic         ov_in_valid, ov_in_last, ov_out_ready;
  logic [15:0]  ov_in_a, ov_in_b;
  logic [1:0]   ov_in_mode;
  logic         ovs_in_ready, ovs_out_valid, ovs_out_ovf;
  logic [10:0]  ovs_out_sum;
  logic         ovw_in_ready, ovw_out_valid, ovw_out_ovf;
  logic [10:0]  ovw_out_sum;

  int checks = 0;
  int failures = 0;

  alu_add_accum dut (
    .Clk(Clk), .Rst(Rst),
    .In_Valid(in_valid), .In_Ready(in_ready),
    .In_A(in_a), .In_B(in_b), .In_Mode(in_mode), .In_Last(in_last),
    .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Out_Sum(out_sum), .Out_Ovf(out_ovf)
  );

  alu_add_accum #(.WIDTH(8), .LANES(2), .ACC_WIDTH(11), .SAT(1)) dut_sat (
    .Clk(Clk), .Rst(Rst),
    .In_Valid(ov_in_valid), .In_Ready(ovs_in_ready),
    .In_A(ov_in_a), .In_B(ov_in_b), .In_Mode(ov_in_mode), .In_Last(ov_in_last),
    .Out_Valid(ovs_out_valid), .Out_Ready(ov_out_ready),
    .Out_Sum(ovs_out_sum), .Out_Ovf(ovs_out_ovf)
  );

  alu_add_accum #(.WIDTH(8), .LANES(2), .ACC_WIDTH(11), .SAT(0)) dut_wrap (
    .Clk(Clk), .Rst(Rst),
    .In_Valid(ov_in_valid), .In_Ready(ovw_in_ready),
    .In_A(ov_in_a), .In_B(ov_in_b), .In_Mode(ov_in_mode), .In_Last(ov_in_last),
    .Out_Valid(ovw_out_valid), .Out_Ready(ov_out_ready),
    .Out_Sum(ovw_out_sum), .Out_Ovf(ovw_out_ovf)
  );

  function automatic logic [127:0] pack4(input logic [31:0] x0, x1, x2, x3);
    return {x3, x2, x1, x0};
  endfunction

  // Called and returns 1 time unit after a rising edge; the beat is accepted on the edge inside.
  task automatic send_beat(input logic [127:0] a, input logic [127:0] b,
                           input logic [1:0] m, input logic l);
    in_a = a; in_b = b; in_mode = m; in_last = l; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    Rst = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 2'b00; in_last = 1'b0; out_ready = 1'b1;
    ov_in_valid = 1'b0; ov_in_a = '0; ov_in_b = '0; ov_in_mode = 2'b00; ov_in_last = 1'b0;
    ov_out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    $display("reset: in_ready=%0d out_valid=%0d out_sum=%0d out_ovf=%0d", in_ready, out_valid, out_sum, out_ovf);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0d expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
    checks++; if (out_sum !== 40'd0) begin failures++; $display("FAIL reset_out_sum: got %0h expected 0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf: got %0d expected 0", out_ovf); end
    Rst = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_add_single;
    send_beat(pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 2'b00, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid: got %0d expected 0", out_valid); end
    @(posedge Clk); #1;
    $display("add_single: valid=%0d sum=%0d ovf=%0d", out_valid, out_sum, out_ovf);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid: got %0d expected 1", out_valid); end
    checks++; if (out_sum !== 40'd110) begin failures++; $display("FAIL add_sum: got %0d expected 110", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL add_ovf: got %0d expected 0", out_ovf); end
    @(posedge Clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_valid_drop: got %0d expected 0", out_valid); end
  endtask

  task automatic test_absdiff_packet;
    send_beat(pack4(5, 5, 5, 5), pack4(3, 8, 5, 0), 2'b10, 1'b0);
    send_beat(pack4(0, 0, 0, 0), pack4(1, 1, 1, 1), 2'b01, 1'b0);
    send_beat(pack4(255, 255, 255, 255), pack4(0, 0, 0, 0), 2'b01, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abs_early_valid: got %0d expected 0", out_valid); end
    @(posedge Clk); #1;
    $display("absdiff_3beat: valid=%0d sum=%0d ovf=%0d", out_valid, out_sum, out_ovf);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL abs_valid: got %0d expected 1", out_valid); end
    checks++; if (out_sum !== 40'd1034) begin failures++; $display("FAIL abs_sum: got %0d expected 1034", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL abs_ovf: got %0d expected 0", out_ovf); end
    @(posedge Clk); #1;
  endtask

  task automatic test_sub_negative;
    send_beat(pack4(0, 0, 0, 0), pack4(1, 2, 3, 4), 2'b01, 1'b1);
    @(posedge Clk); #1;
    $display("sub_negative: valid=%0d sum=%0h ovf=%0d", out_valid, out_sum, out_ovf);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sub_valid: got %0d expected 1", out_valid); end
    checks++; if (out_sum !== 40'hFFFFFFFFF6) begin failures++; $display("FAIL sub_sum: got %0h expected fffffffff6", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL sub_ovf: got %0d expected 0", out_ovf); end
    @(posedge Clk); #1;
  endtask

  task automatic test_overflow;
    ov_in_a = {8'd127, 8'd127};
    ov_in_b = {8'd127, 8'd127};
    ov_in_mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      ov_in_last = (i == 3);
      ov_in_valid = 1'b1;
      @(posedge Clk); #1;
    end
    ov_in_valid = 1'b0;
    ov_in_last = 1'b0;
    @(posedge Clk); #1;
    $display("overflow: sat sum=%0h ovf=%0d | wrap sum=%0h ovf=%0d", ovs_out_sum, ovs_out_ovf, ovw_out_sum, ovw_out_ovf);
    checks++; if (ovs_out_valid !== 1'b1) begin failures++; $display("FAIL ovf_sat_valid: got %0d expected 1", ovs_out_valid); end
    checks++; if (ovs_out_sum !== 11'h3FF) begin failures++; $display("FAIL ovf_sat_sum: got %0h expected 3ff", ovs_out_sum); end
    checks++; if (ovs_out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sat_flag: got %0d expected 1", ovs_out_ovf); end
    checks++; if (ovw_out_sum !== 11'h7F0) begin failures++; $display("FAIL ovf_wrap_sum: got %0h expected 7f0", ovw_out_sum); end
    checks++; if (ovw_out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_wrap_flag: got %0d expected 1", ovw_out_ovf); end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_pressure;
    out_ready = 1'b0;
    in_a = pack4(1, 2, 3, 4); in_b = '0; in_mode = 2'b00; in_last = 1'b1; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_a = pack4(2, 4, 6, 8);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    $display("bp_stall: valid=%0d in_ready=%0d sum=%0d", out_valid, in_ready, out_sum);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %0d expected 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %0d expected 0", in_ready); end
    checks++; if (out_sum !== 40'd10) begin failures++; $display("FAIL bp_first_sum: got %0d expected 10", out_sum); end
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      checks++; if (out_sum !== 40'd10) begin failures++; $display("FAIL bp_hold_sum: cycle %0d got %0d expected 10", i, out_sum); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid: cycle %0d got %0d expected 1", i, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %0d expected 1", in_ready); end
    @(posedge Clk); #1;
    $display("bp_release: valid=%0d sum=%0d", out_valid, out_sum);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_second_valid: got %0d expected 1", out_valid); end
    checks++; if (out_sum !== 40'd20) begin failures++; $display("FAIL bp_second_sum: got %0d expected 20", out_sum); end
    @(posedge Clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got %0d expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] ta [5];
    logic [127:0] tb [5];
    logic [1:0]   tm [5];
    logic         tl [5];
    logic [39:0]  exp_sum [4];
    int           exp_cyc [4];
    logic [39:0]  got_sum [$];
    int           got_cyc [$];
    ta[0] = pack4(1, 0, 0, 0);            tb[0] = '0;                tm[0] = 2'b00; tl[0] = 1'b1;
    ta[1] = pack4(2, 0, 0, 0);            tb[1] = '0;                tm[1] = 2'b00; tl[1] = 1'b0;
    ta[2] = pack4(3, 0, 0, 0);            tb[2] = pack4(1, 0, 0, 0); tm[2] = 2'b01; tl[2] = 1'b1;
    ta[3] = pack4(32'hFFFFFFFF, 0, 0, 0); tb[3] = '0;                tm[3] = 2'b10; tl[3] = 1'b1;
    ta[4] = pack4(7, 0, 0, 0);            tb[4] = pack4(1, 0, 0, 0); tm[4] = 2'b11; tl[4] = 1'b1;
    exp_sum[0] = 40'd1; exp_sum[1] = 40'd6; exp_sum[2] = 40'd4294967295; exp_sum[3] = 40'd8;
    exp_cyc[0] = 1;     exp_cyc[1] = 3;     exp_cyc[2] = 4;              exp_cyc[3] = 5;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 5) begin
        in_a = ta[c]; in_b = tb[c]; in_mode = tm[c]; in_last = tl[c]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      @(posedge Clk); #1;
      if (out_valid === 1'b1) begin
        got_sum.push_back(out_sum);
        got_cyc.push_back(c);
        $display("b2b: cycle=%0d sum=%0d ovf=%0d", c, out_sum, out_ovf);
      end
    end
    checks++;
    if (got_sum.size() != 4) begin
      failures++; $display("FAIL b2b_count: got %0d results expected 4", got_sum.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_sum[i] !== exp_sum[i]) begin failures++; $display("FAIL b2b_sum[%0d]: got %0d expected %0d", i, got_sum[i], exp_sum[i]); end
        checks++; if (got_cyc[i] != exp_cyc[i]) begin failures++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], exp_cyc[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_packet;
    send_beat(pack4(5, 5, 5, 5), pack4(3, 8, 5, 0), 2'b10, 1'b0);
    send_beat(pack4(0, 0, 0, 0), pack4(1, 1, 1, 1), 2'b10, 1'b0);
    #2;
    Rst = 1'b0;
    #1;
    $display("reset_mid: valid=%0d sum=%0d ovf=%0d in_ready=%0d", out_valid, out_sum, out_ovf, in_ready);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %0d expected 0", out_valid); end
    checks++; if (out_sum !== 40'd0) begin failures++; $display("FAIL rstmid_sum: got %0d expected 0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL rstmid_ovf: got %0d expected 0", out_ovf); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready: got %0d expected 1", in_ready); end
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    send_beat(pack4(9, 0, 0, 0), pack4(0, 0, 0, 0), 2'b00, 1'b1);
    @(posedge Clk); #1;
    $display("reset_mid_after: valid=%0d sum=%0d ovf=%0d", out_valid, out_sum, out_ovf);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_after_valid: got %0d expected 1", out_valid); end
    checks++; if (out_sum !== 40'd9) begin failures++; $display("FAIL rstmid_after_sum: got %0d expected 9", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL rstmid_after_ovf: got %0d expected 0", out_ovf); end
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_add_single();
    test_absdiff_packet();
    test_sub_negative();
    test_overflow();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
